// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode.
// A circular FIFO of {adel, pc, instr} entries with a show-ahead head.
// Fetch is throttled early through fetch_afull, and a flush discards everything.
module inst_buffer #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_instr,
    input  logic [31:0]              fetch_pc,
    input  logic                     fetch_adel,
    output logic                     fetch_ready,
    output logic                     fetch_afull,
    input  logic                     stallD,
    output logic                     validD,
    output logic [31:0]              instrD,
    output logic [31:0]              pcD,
    output logic                     adelD,
    output logic [$clog2(DEPTH):0]   countD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_AFULL = CW'(AFULL_LVL);

    logic [64:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_notEmpty;
    logic [64:0]   w_head;

    assign w_notEmpty = (r_count != '0);
    assign w_head     = r_mem[r_rdPtr];

    // Only a live, unflushed cycle may move data; reset and flush swallow any push or pop.
    assign w_push = fetch_valid & fetch_ready & ~flush & ~rst;
    assign w_pop  = validD & ~stallD & ~flush;

    // Status and head outputs come straight from the registered count and the entry at rd_ptr;
    // reset forces the idle view so decode never sees stale data while the core is held.
    always_comb begin
        fetch_ready = rst | (r_count < L_DEPTH);
        fetch_afull = ~rst & (r_count >= L_AFULL);
        validD      = ~rst & w_notEmpty;
        countD      = rst ? '0 : r_count;
        instrD      = 32'h0;
        pcD         = 32'h0;
        adelD       = 1'b0;
        if (validD) begin
            instrD = w_head[31:0];
            pcD    = w_head[63:32];
            adelD  = w_head[64];
        end
    end

    // Pointer and occupancy bookkeeping; reset beats flush, and flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no clearing because validD hides anything not yet written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {fetch_adel, fetch_pc, fetch_instr};
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer: directed scenarios plus a randomized run against a queue model.
module tb_inst_buffer;

    localparam int DEPTH     = 8;
    localparam int AFULL_LVL = 6;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic [31:0]   fetch_pc;
    logic          fetch_adel;
    logic          stallD;
    logic          fetch_ready;
    logic          fetch_afull;
    logic          validD;
    logic [31:0]   instrD;
    logic [31:0]   pcD;
    logic          adelD;
    logic [CW-1:0] countD;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer contents in order, head at index 0.
    logic [64:0] mq[$];

    inst_buffer #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_adel(fetch_adel), .fetch_ready(fetch_ready), .fetch_afull(fetch_afull),
        .stallD(stallD), .validD(validD), .instrD(instrD), .pcD(pcD), .adelD(adelD),
        .countD(countD)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                         input logic adel, input logic stall, input logic fl, input logic r);
        fetch_valid = fv;
        fetch_instr = instr;
        fetch_pc    = pc;
        fetch_adel  = adel;
        stallD      = stall;
        flush       = fl;
        rst         = r;
    endtask

    // Advance one clock and apply the buffer's rules to the model from the held inputs.
    task automatic tick();
        bit mReady, mValid, mPush, mPop;
        @(posedge clk);
        mReady = (mq.size() < DEPTH);
        mValid = (mq.size() != 0);
        mPush  = fetch_valid && mReady && !flush;
        mPop   = mValid && !stallD && !flush;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (mPop) mq.delete(0);
            if (mPush) mq.push_back({fetch_adel, fetch_pc, fetch_instr});
        end
        #1;
    endtask

    task automatic step(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic adel, input logic stall, input logic fl, input logic r);
        drive(fv, instr, pc, adel, stall, fl, r);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold_validD: got %0h expected 0", validD); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_hold_ready: got %0h expected 1", fetch_ready); end
        tick();
        checks++; if (instrD !== 32'h0) begin errors++; $display("[TB] FAIL reset_instrD: got %h expected 0", instrD); end
        checks++; if (pcD !== 32'h0) begin errors++; $display("[TB] FAIL reset_pcD: got %h expected 0", pcD); end
        checks++; if (adelD !== 1'b0) begin errors++; $display("[TB] FAIL reset_adelD: got %0h expected 0", adelD); end
        checks++; if (fetch_afull !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull: got %0h expected 0", fetch_afull); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (countD !== CW'(0)) begin errors++; $display("[TB] FAIL reset_countD: got %0d expected 0", countD); end
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL reset_validD: got %0h expected 0", validD); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 1", fetch_ready); end
        tick();
    endtask

    task automatic test_fill_order();
        logic [31:0] expPc;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, $urandom, 32'hBFC00000 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if (countD !== CW'(i + 1)) begin errors++; $display("[TB] FAIL fill_count: got %0d expected %0d", countD, i + 1); end
            checks++; if (fetch_afull !== ((i + 1) >= AFULL_LVL)) begin errors++; $display("[TB] FAIL fill_afull: got %0h expected %0h at count %0d", fetch_afull, ((i + 1) >= AFULL_LVL), i + 1); end
            checks++; if (fetch_ready !== ((i + 1) < DEPTH)) begin errors++; $display("[TB] FAIL fill_ready: got %0h expected %0h at count %0d", fetch_ready, ((i + 1) < DEPTH), i + 1); end
            checks++; if (pcD !== 32'hBFC00000) begin errors++; $display("[TB] FAIL fill_head: got %h expected bfc00000", pcD); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            expPc = 32'hBFC00000 + 32'(4 * i);
            checks++; if (validD !== 1'b1 || pcD !== expPc) begin errors++; $display("[TB] FAIL drain_order: got v=%0h pc=%h expected v=1 pc=%h", validD, pcD, expPc); end
            checks++; if (instrD !== mq[0][31:0]) begin errors++; $display("[TB] FAIL drain_instr: got %h expected %h", instrD, mq[0][31:0]); end
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++; if (validD !== 1'b0 || instrD !== 32'h0 || pcD !== 32'h0) begin errors++; $display("[TB] FAIL drain_empty: got v=%0h instr=%h pc=%h expected 0 0 0", validD, instrD, pcD); end
    endtask

    task automatic test_passthrough();
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL pass_pre: got %0h expected 0", validD); end
        drive(1'b1, 32'h24020001, 32'hBFC00100, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL pass_bypass: got %0h expected 0", validD); end
        tick();
        checks++; if (validD !== 1'b1 || instrD !== 32'h24020001) begin errors++; $display("[TB] FAIL pass_visible: got v=%0h instr=%h expected v=1 instr=24020001", validD, instrD); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL pass_popped: got %0h expected 0", validD); end
    endtask

    task automatic test_wrap();
        logic [31:0] base = 32'h00400000;
        int pushIdx = 0;
        int popIdx = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, base + 32'(4 * pushIdx), 1'b0, 1'b1, 1'b0, 1'b0);
            pushIdx++;
        end
        for (int i = 0; i < 12; i++) begin
            checks++; if (countD !== CW'(3)) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 3", countD); end
            checks++; if (pcD !== base + 32'(4 * popIdx)) begin errors++; $display("[TB] FAIL wrap_order: got %h expected %h", pcD, base + 32'(4 * popIdx)); end
            step(1'b1, $urandom, base + 32'(4 * pushIdx), 1'b0, 1'b0, 1'b0, 1'b0);
            pushIdx++;
            popIdx++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pcD !== base + 32'(4 * popIdx)) begin errors++; $display("[TB] FAIL wrap_drain: got %h expected %h", pcD, base + 32'(4 * popIdx)); end
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            popIdx++;
        end
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty: got %0h expected 0", validD); end
    endtask

    task automatic test_flush_collision();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom, 32'h80000000 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (countD !== CW'(5)) begin errors++; $display("[TB] FAIL flush_pre: got %0d expected 5", countD); end
        step(1'b1, $urandom, 32'h80000100, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (countD !== CW'(0) || validD !== 1'b0) begin errors++; $display("[TB] FAIL flush_clear: got cnt=%0d v=%0h expected 0 0", countD, validD); end
        checks++; if (instrD !== 32'h0 || pcD !== 32'h0) begin errors++; $display("[TB] FAIL flush_head: got instr=%h pc=%h expected 0 0", instrD, pcD); end
        step(1'b1, 32'h3C1DBFC0, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (validD !== 1'b1 || pcD !== 32'h12345678 || countD !== CW'(1)) begin errors++; $display("[TB] FAIL flush_after: got v=%0h pc=%h cnt=%0d expected 1 12345678 1", validD, pcD, countD); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        logic [31:0] base = 32'hA0000000;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, $urandom, base + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (countD !== CW'(DEPTH) || fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_pre: got cnt=%0d rdy=%0h expected %0d 0", countD, fetch_ready, DEPTH); end
        drive(1'b1, $urandom, 32'hDEADBEEC, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_pop: got %0h expected 0", fetch_ready); end
        tick();
        checks++; if (countD !== CW'(DEPTH - 1) || pcD !== base + 32'd4) begin errors++; $display("[TB] FAIL full_pop: got cnt=%0d pc=%h expected %0d %h", countD, pcD, DEPTH - 1, base + 32'd4); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (pcD !== base + 32'(4 * i) || adelD !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got pc=%h adel=%0h expected %h 0", pcD, adelD, base + 32'(4 * i)); end
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL full_empty: got %0h expected 0", validD); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, 32'h90000000 + 32'(4 * i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (countD !== CW'(4)) begin errors++; $display("[TB] FAIL rstmid_pre: got %0d expected 4", countD); end
        step(1'b1, $urandom, 32'h90000100, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (countD !== CW'(0) || validD !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_clear: got cnt=%0d v=%0h rdy=%0h expected 0 0 1", countD, validD, fetch_ready); end
        tick();
        step(1'b1, 32'h8FBF0010, 32'hBFC00200, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (validD !== 1'b1 || pcD !== 32'hBFC00200 || adelD !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_head: got v=%0h pc=%h adel=%0h expected 1 bfc00200 1", validD, pcD, adelD); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic        expV;
        logic [31:0] expI, expP;
        logic        expA;
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 10) < 7, $urandom, $urandom, 1'($urandom % 2),
                 ($urandom % 10) < 4, ($urandom % 40) == 0, ($urandom % 80) == 0);
            expV = (mq.size() != 0);
            expI = expV ? mq[0][31:0]  : 32'h0;
            expP = expV ? mq[0][63:32] : 32'h0;
            expA = expV ? mq[0][64]    : 1'b0;
            checks++; if (validD !== expV) begin errors++; $display("[TB] FAIL rand_validD: got %0h expected %0h cycle %0d", validD, expV, n); end
            checks++; if (instrD !== expI) begin errors++; $display("[TB] FAIL rand_instrD: got %h expected %h cycle %0d", instrD, expI, n); end
            checks++; if (pcD !== expP) begin errors++; $display("[TB] FAIL rand_pcD: got %h expected %h cycle %0d", pcD, expP, n); end
            checks++; if (adelD !== expA) begin errors++; $display("[TB] FAIL rand_adelD: got %0h expected %0h cycle %0d", adelD, expA, n); end
            checks++; if (countD !== CW'(mq.size())) begin errors++; $display("[TB] FAIL rand_countD: got %0d expected %0d cycle %0d", countD, mq.size(), n); end
            checks++; if (fetch_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_ready: got %0h expected %0h cycle %0d", fetch_ready, (mq.size() < DEPTH), n); end
            checks++; if (fetch_afull !== (mq.size() >= AFULL_LVL)) begin errors++; $display("[TB] FAIL rand_afull: got %0h expected %0h cycle %0d", fetch_afull, (mq.size() >= AFULL_LVL), n); end
        end
    endtask

    // Scenario sequence, then the summary line.
    initial begin
        $display("[TB] inst_buffer bench start");
        test_reset();
        test_fill_order();
        test_passthrough();
        test_wrap();
        test_flush_collision();
        test_full_pop();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
